// File: rtl/pc_fetch_unit.sv
// PC and instruction fetch stage for the 16-bit CPU.
// Issues imem word fetches and hands instructions to decode.
module pc_fetch_unit #(
  parameter int unsigned     ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_valid,
  input  logic              branch_check,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              squash_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       instr_q;
  logic [ADDR_W-1:0] ipc_q;
  logic              vld_q;

  logic              redirect;
  logic              xfer;
  logic [ADDR_W-1:0] addr_inc;

  assign redirect = branch_valid & branch_check;
  assign xfer     = vld_q & instr_ready;
  assign addr_inc = addr_q + 1'b1;

  // Fetch FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      instr_q  <= '0;
      ipc_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (redirect) begin
            pc_q <= branch_target;
          end else if (!stall) begin
            req_q   <= 1'b1;
            addr_q  <= pc_q;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            req_q <= 1'b0;
            if (redirect) begin
              // new target beats both live and stale data
              pc_q     <= branch_target;
              squash_q <= 1'b0;
              state_q  <= IDLE;
            end else if (squash_q) begin
              // pc already holds the redirect target
              squash_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              instr_q <= imem_rdata;
              ipc_q   <= addr_q;
              vld_q   <= 1'b1;
              pc_q    <= addr_inc;
              state_q <= HOLD;
            end
          end else if (redirect) begin
            // keep the request alive; drop its data later
            squash_q <= 1'b1;
            pc_q     <= branch_target;
          end
        end
        HOLD: begin
          if (redirect) begin
            vld_q   <= 1'b0;
            pc_q    <= branch_target;
            state_q <= IDLE;
          end else if (xfer) begin
            vld_q <= 1'b0;
            if (stall) begin
              state_q <= IDLE;
            end else begin
              req_q   <= 1'b1;
              addr_q  <= pc_q;
              state_q <= FETCH;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = vld_q;

  // Memory may only answer an outstanding request.
  ack_needs_req: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_ack |-> imem_req
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit.
// Cycle vectors plus hand sequences for reset and wrap.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bv = 1'b0, bc = 1'b0;
  logic [15:0] bt = '0;
  logic        stall = 1'b0;
  logic        req;
  logic [15:0] addr;
  logic        ack = 1'b0;
  logic [15:0] rdata = '0;
  logic [15:0] instr;
  logic [15:0] ipc;
  logic        vld;
  logic        rdy = 1'b1;

  logic        req2;
  logic [15:0] addr2;
  logic        ack2 = 1'b0;
  logic [15:0] rdata2 = '0;
  logic [15:0] instr2;
  logic [15:0] ipc2;
  logic        vld2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .branch_valid(bv), .branch_check(bc), .branch_target(bt),
    .stall(stall),
    .imem_req(req), .imem_addr(addr),
    .imem_ack(ack), .imem_rdata(rdata),
    .instr(instr), .instr_pc(ipc), .instr_valid(vld),
    .instr_ready(rdy)
  );

  pc_fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .branch_valid(1'b0), .branch_check(1'b0), .branch_target(16'h0000),
    .stall(1'b0),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2),
    .instr(instr2), .instr_pc(ipc2), .instr_valid(vld2),
    .instr_ready(1'b1)
  );

  typedef struct {
    logic        rst_n;
    logic        bv;
    logic        bc;
    logic [15:0] bt;
    logic        stall;
    logic        ack;
    logic [15:0] rdata;
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_vld;
    logic [15:0] e_instr;
    logic [15:0] e_ipc;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic r, input logic b_v, input logic b_c,
    input logic [15:0] b_t, input logic st, input logic ak,
    input logic [15:0] rd, input logic ry,
    input logic e_rq, input logic [15:0] e_ad, input logic e_vl,
    input logic [15:0] e_in, input logic [15:0] e_pc
  );
    vec_t v;
    v.rst_n = r;  v.bv = b_v;  v.bc = b_c;  v.bt = b_t;
    v.stall = st; v.ack = ak;  v.rdata = rd; v.rdy = ry;
    v.e_req = e_rq; v.e_addr = e_ad; v.e_vld = e_vl;
    v.e_instr = e_in; v.e_ipc = e_pc;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rq,
                         input logic [15:0] e_ad, input logic e_vl,
                         input logic [15:0] e_in, input logic [15:0] e_pc);
    chk({tag, ".req"},   16'(req),   16'(e_rq));
    chk({tag, ".addr"},  addr,       e_ad);
    chk({tag, ".vld"},   16'(vld),   16'(e_vl));
    chk({tag, ".instr"}, instr,      e_in);
    chk({tag, ".ipc"},   ipc,        e_pc);
  endtask

  initial begin
    // rst bv bc bt stall ack rdata rdy | req addr vld instr ipc
    add(0,0,0,16'h0000,0,0,16'h0000,1, 0,16'h0000,0,16'h0000,16'h0000);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0000,0,16'h0000,16'h0000);
    add(1,0,0,16'h0000,0,1,16'h1000,1, 0,16'h0000,1,16'h1000,16'h0000);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0001,0,16'h1000,16'h0000);
    add(1,0,0,16'h0000,0,1,16'h1001,1, 0,16'h0001,1,16'h1001,16'h0001);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0002,0,16'h1001,16'h0001);
    add(1,0,0,16'h0000,0,1,16'h1002,1, 0,16'h0002,1,16'h1002,16'h0002);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0003,0,16'h1002,16'h0002);
    add(1,0,0,16'h0000,0,1,16'h1003,1, 0,16'h0003,1,16'h1003,16'h0003);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0004,0,16'h1003,16'h0003);
    // backpressure: hold A5A5 @4 while decode is not ready
    add(1,0,0,16'h0000,0,1,16'hA5A5,0, 0,16'h0004,1,16'hA5A5,16'h0004);
    for (int i = 0; i < 5; i++)
      add(1,0,0,16'h0000,0,0,16'h0000,0, 0,16'h0004,1,16'hA5A5,16'h0004);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0005,0,16'hA5A5,16'h0004);
    add(1,0,0,16'h0000,0,1,16'h2005,1, 0,16'h0005,1,16'h2005,16'h0005);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0006,0,16'h2005,16'h0005);
    add(1,0,0,16'h0000,0,1,16'h2006,1, 0,16'h0006,1,16'h2006,16'h0006);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0007,0,16'h2006,16'h0006);
    // redirect to 0x40 while waiting on addr 7, ack 3 cycles later
    add(1,1,1,16'h0040,0,0,16'h0000,1, 1,16'h0007,0,16'h2006,16'h0006);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0007,0,16'h2006,16'h0006);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0007,0,16'h2006,16'h0006);
    add(1,0,0,16'h0000,0,1,16'hDEAD,1, 0,16'h0007,0,16'h2006,16'h0006);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0040,0,16'h2006,16'h0006);
    add(1,0,0,16'h0000,0,1,16'h3040,1, 0,16'h0040,1,16'h3040,16'h0040);
    // redirect in HOLD with ready=1
    add(1,1,1,16'h0100,0,0,16'h0000,1, 0,16'h0040,0,16'h3040,16'h0040);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0100,0,16'h3040,16'h0040);
    add(1,0,0,16'h0000,0,1,16'h4100,1, 0,16'h0100,1,16'h4100,16'h0100);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0101,0,16'h4100,16'h0100);
    // redirect coincident with ack
    add(1,1,1,16'h0200,0,1,16'hBEEF,1, 0,16'h0101,0,16'h4100,16'h0100);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0200,0,16'h4100,16'h0100);
    // branch_check without branch_valid is ignored
    add(1,0,1,16'h0300,0,1,16'h5200,1, 0,16'h0200,1,16'h5200,16'h0200);
    add(1,0,1,16'h0300,0,0,16'h0000,1, 1,16'h0201,0,16'h5200,16'h0200);
    add(1,0,0,16'h0000,0,1,16'h5201,1, 0,16'h0201,1,16'h5201,16'h0201);
    // stall in HOLD then 4 cycles in IDLE
    add(1,0,0,16'h0000,1,0,16'h0000,1, 0,16'h0201,0,16'h5201,16'h0201);
    for (int i = 0; i < 4; i++)
      add(1,0,0,16'h0000,1,0,16'h0000,1, 0,16'h0201,0,16'h5201,16'h0201);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0202,0,16'h5201,16'h0201);
    // stall mid-FETCH keeps the request
    add(1,0,0,16'h0000,1,0,16'h0000,1, 1,16'h0202,0,16'h5201,16'h0201);
    add(1,0,0,16'h0000,1,0,16'h0000,1, 1,16'h0202,0,16'h5201,16'h0201);
    add(1,0,0,16'h0000,1,1,16'h6202,1, 0,16'h0202,1,16'h6202,16'h0202);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0203,0,16'h6202,16'h0202);
    // two redirects while squashing: last target wins
    add(1,1,1,16'h0500,0,0,16'h0000,1, 1,16'h0203,0,16'h6202,16'h0202);
    add(1,1,1,16'h0600,0,0,16'h0000,1, 1,16'h0203,0,16'h6202,16'h0202);
    add(1,0,0,16'h0000,0,1,16'hDEAD,1, 0,16'h0203,0,16'h6202,16'h0202);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0600,0,16'h6202,16'h0202);
    add(1,0,0,16'h0000,0,1,16'h7600,1, 0,16'h0600,1,16'h7600,16'h0600);
    add(1,0,0,16'h0000,0,0,16'h0000,1, 1,16'h0601,0,16'h7600,16'h0600);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rst_n; bv = vq[i].bv; bc = vq[i].bc; bt = vq[i].bt;
      stall = vq[i].stall; ack = vq[i].ack; rdata = vq[i].rdata;
      rdy = vq[i].rdy;
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), vq[i].e_req, vq[i].e_addr,
              vq[i].e_vld, vq[i].e_instr, vq[i].e_ipc);
    end

    // async reset while a fetch to 0x601 is in flight
    @(negedge clk);
    bv = 0; bc = 0; stall = 0; ack = 0; rdy = 1;
    #1 rst_n = 0;
    #1;
    chk_all("arst", 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    chk("arst.req2", 16'(req2), 16'h0000);
    chk("arst.addr2", addr2, 16'hFFFF);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk_all("rel", 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000);

    // RESET_PC=FFFF instance: FFFF then wrap to 0000
    chk("wrap.req0", 16'(req2), 16'h0001);
    chk("wrap.addr0", addr2, 16'hFFFF);
    @(negedge clk);
    ack2 = 1; rdata2 = 16'h9FFF;
    @(posedge clk);
    #1;
    chk("wrap.vld0", 16'(vld2), 16'h0001);
    chk("wrap.ipc0", ipc2, 16'hFFFF);
    chk("wrap.instr0", instr2, 16'h9FFF);
    @(negedge clk);
    ack2 = 0;
    @(posedge clk);
    #1;
    chk("wrap.req1", 16'(req2), 16'h0001);
    chk("wrap.addr1", addr2, 16'h0000);
    @(negedge clk);
    ack2 = 1; rdata2 = 16'h9000;
    @(posedge clk);
    #1;
    chk("wrap.vld1", 16'(vld2), 16'h0001);
    chk("wrap.ipc1", ipc2, 16'h0000);
    chk("wrap.instr1", instr2, 16'h9000);
    @(negedge clk);
    ack2 = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
